eq_coeff_bank: RTL

Double-buffered biquad coefficient store that serves the equalizer's coefficient read port (`eq_coeff_addr` → `eq_coeff`). A host or register bridge loads it through a valid/ready write stream. Writes land in a shadow bank. A commit swaps banks only while the equalizer is idle between samples, so a sample is never filtered with a mixed coefficient set. After reset, every band is initialised to unity pass-through.

---
 rtl/eq_pkg.sv | 40 ++++
 rtl/eq_coeff_ram.sv | 41 ++++
 rtl/eq_coeff_bank.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// -----------------------------------------------------------------------------
// eq_pkg
// Definitions shared by the biquad equalizer and its coefficient store:
//   - NR_EQ_BAND_COEFF : words per biquad band (a0, a1, a2, -b1, -b2)
//   - EQ_A0..EQ_B2     : word index of each coefficient inside a band
//   - cf_state_e       : coefficient-store controller states
//   - clog2()          : address-width helper usable in parameter expressions
//   - eq_unity()       : fixed-point 1.0 for a given coefficient width
// -----------------------------------------------------------------------------
package eq_pkg;

  localparam int NR_EQ_BAND_COEFF = 5;

  // Feedback terms are stored pre-negated so the equalizer only accumulates.
  localparam int EQ_A0 = 0;
  localparam int EQ_A1 = 1;
  localparam int EQ_A2 = 2;
  localparam int EQ_B1 = 3;
  localparam int EQ_B2 = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,  // sweep both banks to unity pass-through
    ST_LOAD = 2'd1,  // accept writes into the shadow bank
    ST_PEND = 2'd2,  // commit requested, waiting for an idle equalizer
    ST_COPY = 2'd3   // mirror the new active bank into the new shadow bank
  } cf_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Sign + 3 integer bits, remaining bits are fraction.
  function automatic longint unsigned eq_unity(input int width);
    return 64'd1 << (width - 4);
  endfunction

endpackage

// File: rtl/eq_coeff_ram.sv
// -----------------------------------------------------------------------------
// eq_coeff_ram
// One coefficient bank: a block RAM with one write port and two independent
// registered read ports (1-cycle latency).
//   clk       : clock
//   i_we      : write enable
//   i_waddr   : write address (caller guarantees < DEPTH)
//   i_wdata   : write data
//   i_raddr_a : read address, port A (equalizer side)
//   o_rdata_a : registered read data, port A
//   i_raddr_b : read address, port B (copy engine side)
//   o_rdata_b : registered read data, port B
// -----------------------------------------------------------------------------
module eq_coeff_ram #(
  parameter int DEPTH = 160,
  parameter int DW    = 32,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [DEPTH];

  // NOTE: the array and its read registers carry no reset so they map onto
  // block RAM; the controller initialises contents and masks the output.
  // NOTE: non-blocking assignments keep read-before-write ordering well
  // defined for every register updated on this edge.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata_a <= r_mem[i_raddr_a];
    o_rdata_b <= r_mem[i_raddr_b];
  end

endmodule

// File: rtl/eq_coeff_bank.sv
// -----------------------------------------------------------------------------
// eq_coeff_bank
// Double-buffered biquad coefficient store. Host writes land in the shadow
// bank; a commit swaps banks only while the equalizer is idle, then the new
// active bank is mirrored into the new shadow bank so partial updates edit
// the live set.
//   clk, rst_n    : clock, asynchronous active-low reset
//   eq_coeff_addr : equalizer read address
//   eq_coeff      : read data from the active bank, 1-cycle latency, 0 if OOR
//   eq_idle       : equalizer is between samples (safe swap point)
//   s_cf_d        : write data
//   s_cf_addr     : write address
//   s_cf_commit   : request a bank swap with this beat
//   s_cf_dv       : write/commit valid
//   s_cf_dr       : ready (LOAD only)
//   cf_bank       : active bank index
//   cf_err        : one-cycle pulse after an out-of-range write
// -----------------------------------------------------------------------------
module eq_coeff_bank
  import eq_pkg::*;
#(
  parameter int  NR_CHANNELS         = 4,
  parameter int  NR_EQ_BANDS         = 8,
  parameter int  EQ_COEFF_WIDTH      = 32,
  localparam int NR_EQ_COEFF         = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF,
  localparam int EQ_COEFF_ADDR_WIDTH = clog2(NR_EQ_COEFF)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [EQ_COEFF_ADDR_WIDTH-1:0] eq_coeff_addr,
  output logic [EQ_COEFF_WIDTH-1:0]      eq_coeff,
  input  logic                           eq_idle,
  input  logic [EQ_COEFF_WIDTH-1:0]      s_cf_d,
  input  logic [EQ_COEFF_ADDR_WIDTH-1:0] s_cf_addr,
  input  logic                           s_cf_commit,
  input  logic                           s_cf_dv,
  output logic                           s_cf_dr,
  output logic                           cf_bank,
  output logic                           cf_err
);

  localparam int AW = EQ_COEFF_ADDR_WIDTH;
  localparam int DW = EQ_COEFF_WIDTH;
  // COPY counts one step past the last address to drain the read pipeline.
  localparam int CW = clog2(NR_EQ_COEFF + 1);

  localparam logic [DW-1:0] UNITY = DW'(eq_unity(DW));

  cf_state_e r_state;
  cf_state_e w_state_nxt;

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_k;       // coefficient index of r_cnt during INIT
  logic          r_bank;
  logic          r_err;
  logic          r_rd_bank; // bank that produced the word in the read registers
  logic          r_rd_zero; // registered read address was out of range

  logic          w_init_last;
  logic          w_copy_last;
  logic          w_wr_in_range;
  logic          w_rd_in_range;
  logic [1:0]    w_shadow_we;
  logic [1:0]    w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rd_a [2];
  logic [DW-1:0] w_rd_b [2];
  logic [DW-1:0] w_copy_data;

  assign w_init_last   = (r_cnt == CW'(NR_EQ_COEFF - 1));
  assign w_copy_last   = (r_cnt == CW'(NR_EQ_COEFF));
  assign w_wr_in_range = (32'(s_cf_addr) < NR_EQ_COEFF);
  assign w_rd_in_range = (32'(eq_coeff_addr) < NR_EQ_COEFF);
  assign w_shadow_we   = r_bank ? 2'b01 : 2'b10;
  assign w_copy_data   = r_bank ? w_rd_b[1] : w_rd_b[0];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_INIT: if (w_init_last)           w_state_nxt = ST_LOAD;
      ST_LOAD: if (s_cf_dv && s_cf_commit) w_state_nxt = ST_PEND;
      ST_PEND: if (eq_idle)               w_state_nxt = ST_COPY;
      ST_COPY: if (w_copy_last)           w_state_nxt = ST_LOAD;
      default:                            w_state_nxt = ST_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (ready and the shared bank write port)
  // --------------------------------------------------------------------------
  always_comb begin
    s_cf_dr = 1'b0;
    w_we    = 2'b00;
    w_waddr = '0;
    w_wdata = '0;
    unique case (r_state)
      ST_INIT: begin
        w_we    = 2'b11;
        w_waddr = AW'(r_cnt);
        w_wdata = (r_k == 3'(EQ_A0)) ? UNITY : '0;
      end
      ST_LOAD: begin
        s_cf_dr = 1'b1;
        if (s_cf_dv && w_wr_in_range) begin
          w_we    = w_shadow_we;
          w_waddr = s_cf_addr;
          w_wdata = s_cf_d;
        end
      end
      ST_COPY: begin
        // Read of address n issued in cycle n lands in cycle n+1.
        if (r_cnt != '0) begin
          w_we    = w_shadow_we;
          w_waddr = AW'(r_cnt - CW'(1));
          w_wdata = w_copy_data;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sweep counters for INIT and COPY
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_k   <= '0;
    end else begin
      unique case (r_state)
        ST_INIT: begin
          if (w_init_last) begin
            r_cnt <= '0;
            r_k   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            r_k   <= (r_k == 3'(EQ_B2)) ? 3'd0 : r_k + 3'd1;
          end
        end
        ST_COPY: r_cnt <= w_copy_last ? '0 : r_cnt + CW'(1);
        default: begin
          r_cnt <= '0;
          r_k   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bank select, error pulse and read-side tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_bank <= 1'b0;
      r_rd_zero <= 1'b1;
    end else begin
      if (r_state == ST_PEND && eq_idle) r_bank <= ~r_bank;
      r_err     <= (r_state == ST_LOAD) && s_cf_dv && !w_wr_in_range;
      // Sampled with the address, so a swap affects only reads issued after it.
      r_rd_bank <= r_bank;
      r_rd_zero <= !w_rd_in_range;
    end
  end

  // --------------------------------------------------------------------------
  // Banks: port A serves the equalizer, port B feeds the copy engine
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < 2; b++) begin : g_bank
    eq_coeff_ram #(
      .DEPTH (NR_EQ_COEFF),
      .DW    (DW),
      .AW    (AW)
    ) u_ram (
      .clk       (clk),
      .i_we      (w_we[b]),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (eq_coeff_addr),
      .o_rdata_a (w_rd_a[b]),
      .i_raddr_b (AW'(r_cnt)),
      .o_rdata_b (w_rd_b[b])
    );
  end

  assign eq_coeff = r_rd_zero ? '0 : (r_rd_bank ? w_rd_a[1] : w_rd_a[0]);
  assign cf_bank  = r_bank;
  assign cf_err   = r_err;

endmodule
